bin_to_bcd: RTL

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Sits directly upstream of the `seven_seg` decoders. It accepts a W-bit unsigned value on a start pulse and produces DIGITS packed 4-bit BCD digits, one per decoder. Outputs are registered and held stable between conversions, so the display never shows intermediate values.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter and its digit correction cell.
package bcd_pkg;

    localparam int BCD_DIGIT_W     = 4;
    localparam int BCD_ADD3_THRESH = 5;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } b2b_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 (mod 16) before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);

    assign d_out = (d_in >= bcd_digit_t'(BCD_ADD3_THRESH)) ? d_in + bcd_digit_t'(3) : d_in;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking is enabled by defining BIN_TO_BCD_LEADING_BLANK_EN.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [W-1:0]                  bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow,
    output logic [DIGITS-1:0]             blank
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    b2b_state_t       state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [BCD_W-1:0] adj;
    logic             ovf_scr_q, ovf_scr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             last_shift;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d_in  (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .d_out (adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_scr_d  = ovf_scr_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        last_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    shift_d   = bin;
                    scratch_d = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                // Whatever leaves the top digit is a multiple of 10^DIGITS, hence overflow.
                scratch_d = {adj[BCD_W-2:0], shift_q[W-1]};
                shift_d   = shift_q << 1;
                ovf_scr_d = ovf_scr_q | adj[BCD_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    last_shift = 1'b1;
                    state_d    = IDLE;
                    bcd_d      = scratch_d;
                    overflow_d = ovf_scr_d;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_scr_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_scr_q  <= ovf_scr_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    // Digit 0 is never blanked so a zero result still shows a single "0".
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_calc;
    logic [DIGITS-1:0] blank_q, blank_d;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign blank_calc[gi] = 1'b0;
            end else begin : g_upper
                assign blank_calc[gi] = ~|scratch_d[BCD_W-1:gi*BCD_DIGIT_W];
            end
        end
    endgenerate

    always_comb begin
        blank_d = blank_q;
        if (last_shift) begin
            blank_d = blank_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
